// File: rtl/memory_access_cycle.sv
// memory_access_cycle: SimpleRisc M stage, multi-cycle ld/st on word memory, stall and M/W buffer.
module memory_access_cycle #(
  parameter int MEM_AW  = 10,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_M,
  input  logic [31:0] alu_result_M,
  input  logic [31:0] rd2_M,
  input  logic [31:0] instruction_M,
  input  logic        isSt_M,
  input  logic        isLd_M,
  input  logic        isWb_M,
  input  logic        isCall_M,
  input  logic [3:0]  RD_M,
  input  logic [3:0]  ra_M,
  output logic [31:0] data_M_E,
  output logic        stall_M,
  output logic [31:0] pc_W,
  output logic [31:0] alu_result_W,
  output logic [31:0] ld_result_W,
  output logic [31:0] instruction_W,
  output logic        isWb_W,
  output logic        isLd_W,
  output logic        isCall_W,
  output logic [3:0]  RD_W,
  output logic [3:0]  ra_W
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam bit MULTI = MEM_LAT > 1;
  localparam logic [3:0] CNT_INIT = 4'(MULTI ? MEM_LAT - 2 : 0);
  state_t r_state;
  logic [3:0] r_cnt;
  logic [31:0] r_mem [2**MEM_AW] = '{default: '0};
  logic w_mem, w_stall;
  logic [MEM_AW-1:0] w_idx;
  assign w_mem = isLd_M | isSt_M;
  assign w_idx = alu_result_M[MEM_AW+1:2];
  // BUSY holds the stage until the counter drains; the cycle after that is the completion cycle
  assign w_stall = !rst && (r_state == IDLE ? (w_mem && MULTI) : (r_cnt != 4'd0));
  assign stall_M = w_stall;
  assign data_M_E = alu_result_M;
  always_ff @(posedge clk)
    if (!rst && !w_stall && isSt_M) r_mem[w_idx] <= rd2_M;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= 4'd0;
      pc_W          <= '0;
      alu_result_W  <= '0;
      ld_result_W   <= '0;
      instruction_W <= '0;
      isWb_W        <= 1'b0;
      isLd_W        <= 1'b0;
      isCall_W      <= 1'b0;
      RD_W          <= '0;
      ra_W          <= '0;
    end else begin
      r_state       <= w_stall ? BUSY : IDLE;
      r_cnt         <= w_stall ? (r_state == IDLE ? CNT_INIT : r_cnt - 4'd1) : r_cnt;
      pc_W          <= w_stall ? '0 : pc_M;
      alu_result_W  <= w_stall ? '0 : alu_result_M;
      ld_result_W   <= (w_stall || !w_mem) ? '0 : r_mem[w_idx];
      instruction_W <= w_stall ? '0 : instruction_M;
      isWb_W        <= !w_stall && isWb_M;
      isLd_W        <= !w_stall && isLd_M;
      isCall_W      <= !w_stall && isCall_M;
      RD_W          <= w_stall ? '0 : RD_M;
      ra_W          <= w_stall ? '0 : ra_M;
    end
  end
endmodule

// File: tb/tb_memory_access_cycle.sv
// tb_memory_access_cycle: randomized and directed checks of the M stage at MEM_LAT=1 and MEM_LAT=3.
module tb_memory_access_cycle;
  typedef struct packed {
    logic [31:0] pc, alu, rd2, ins;
    logic st, ld, wb, call;
    logic [3:0] rd, ra;
  } in_t;
  typedef struct packed {
    logic [31:0] pc, alu, ldr, ins;
    logic wb, ld, call;
    logic [3:0] rd, ra;
  } out_t;
  logic clk = 0, rst = 1;
  in_t a1 = '0, a3 = '0;
  out_t o1, o3;
  logic [31:0] f1, f3;
  logic s1, s3;
  logic [31:0] m1 [1024], m3 [1024];
  int passed = 0, total = 0;
  always #5 clk = ~clk;

  memory_access_cycle #(.MEM_AW(10), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .pc_M(a1.pc), .alu_result_M(a1.alu), .rd2_M(a1.rd2),
    .instruction_M(a1.ins), .isSt_M(a1.st), .isLd_M(a1.ld), .isWb_M(a1.wb), .isCall_M(a1.call),
    .RD_M(a1.rd), .ra_M(a1.ra), .data_M_E(f1), .stall_M(s1), .pc_W(o1.pc),
    .alu_result_W(o1.alu), .ld_result_W(o1.ldr), .instruction_W(o1.ins), .isWb_W(o1.wb),
    .isLd_W(o1.ld), .isCall_W(o1.call), .RD_W(o1.rd), .ra_W(o1.ra));
  memory_access_cycle #(.MEM_AW(10), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst), .pc_M(a3.pc), .alu_result_M(a3.alu), .rd2_M(a3.rd2),
    .instruction_M(a3.ins), .isSt_M(a3.st), .isLd_M(a3.ld), .isWb_M(a3.wb), .isCall_M(a3.call),
    .RD_M(a3.rd), .ra_M(a3.ra), .data_M_E(f3), .stall_M(s3), .pc_W(o3.pc),
    .alu_result_W(o3.alu), .ld_result_W(o3.ldr), .instruction_W(o3.ins), .isWb_W(o3.wb),
    .isLd_W(o3.ld), .isCall_W(o3.call), .RD_W(o3.rd), .ra_W(o3.ra));

  function automatic in_t mk(input bit ld, input bit st, input bit wb, input logic [31:0] alu,
                             input logic [31:0] rd2, input logic [3:0] rd);
    in_t x;
    x.pc = $urandom; x.ins = $urandom; x.ra = 4'($urandom); x.call = 1'b0;
    x.ld = ld; x.st = st; x.wb = wb; x.alu = alu; x.rd2 = rd2; x.rd = rd;
    return x;
  endfunction

  // Reference: a word memory indexed by (address / 4) mod depth; a ld/st spends LAT cycles in M.
  task automatic model(input bit s, input in_t x, output out_t e, output int es);
    int idx;
    logic [31:0] w;
    idx = int'((x.alu / 4) % 1024);
    w = s ? m3[idx] : m1[idx];
    e = '{pc: x.pc, alu: x.alu, ldr: (x.ld | x.st) ? w : 32'h0, ins: x.ins,
          wb: x.wb, ld: x.ld, call: x.call, rd: x.rd, ra: x.ra};
    if (x.st) begin
      if (s) m3[idx] = x.rd2; else m1[idx] = x.rd2;
    end
    es = (x.ld | x.st) ? (s ? 2 : 0) : 0;
  endtask

  // Drives one instruction from a negedge, holds it while stalled, returns what W shows after completion.
  task automatic issue(input bit s, input in_t x, output int stalls, output bit bub_bad, output out_t o);
    logic st;
    stalls = 0; bub_bad = 0;
    if (s) a3 = x; else a1 = x;
    for (int k = 0; k < 20; k++) begin
      #1 st = s ? s3 : s1;
      @(posedge clk); #1;
      if (!st) break;
      stalls++;
      if ((s ? o3 : o1) !== '0) bub_bad = 1;
      @(negedge clk);
    end
    o = s ? o3 : o1;
    @(negedge clk);
    if (s) a3 = '0; else a1 = '0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (o1 !== '0) $display("FAIL reset_w1 got %h want 0", o1); else passed++;
    total++; if (o3 !== '0) $display("FAIL reset_w3 got %h want 0", o3); else passed++;
    total++; if ({s1, s3} !== 2'b00) $display("FAIL reset_stall got %b want 00", {s1, s3}); else passed++;
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_lat1;
    out_t o, e; int st, es; bit bb;
    model(0, mk(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'd0), e, es);
    issue(0, mk(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'd0), st, bb, o);
    total++; if (st !== 0) $display("FAIL lat1_st_stall got %0d want 0", st); else passed++;
    model(0, mk(1, 0, 1, 32'h10, 32'h0, 4'd7), e, es);
    issue(0, mk(1, 0, 1, 32'h10, 32'h0, 4'd7), st, bb, o);
    total++; if (st !== 0) $display("FAIL lat1_ld_stall got %0d want 0", st); else passed++;
    total++; if (o.ldr !== 32'hDEADBEEF) $display("FAIL lat1_ld got %h want deadbeef", o.ldr); else passed++;
    total++; if (o.ld !== 1'b1) $display("FAIL lat1_isLd got %b want 1", o.ld); else passed++;
  endtask

  task automatic test_lat3_load;
    out_t o, e; int st, es; bit bb; in_t x;
    x = mk(0, 1, 0, 32'h20, 32'h12345678, 4'd0);
    model(1, x, e, es); issue(1, x, st, bb, o);
    total++; if (o !== e) $display("FAIL lat3_st_w got %h want %h", o, e); else passed++;
    x = mk(1, 0, 1, 32'h20, 32'h0, 4'd9);
    model(1, x, e, es); issue(1, x, st, bb, o);
    total++; if (st !== 2) $display("FAIL lat3_stalls got %0d want 2", st); else passed++;
    total++; if (bb !== 1'b0) $display("FAIL lat3_bubble got %b want 0", bb); else passed++;
    total++; if (o.ldr !== 32'h12345678) $display("FAIL lat3_ld got %h want 12345678", o.ldr); else passed++;
    total++; if ({o.wb, o.rd} !== 5'h19) $display("FAIL lat3_wb_rd got %h want 19", {o.wb, o.rd}); else passed++;
  endtask

  task automatic test_alu;
    out_t o, e; int st, es; bit bb; in_t x;
    x = mk(0, 0, 1, 32'h55, 32'h0, 4'd4);
    a3 = x; #1;
    total++; if (f3 !== 32'h55) $display("FAIL alu_fwd got %h want 55", f3); else passed++;
    model(1, x, e, es); issue(1, x, st, bb, o);
    total++; if (st !== 0) $display("FAIL alu_stall got %0d want 0", st); else passed++;
    total++; if ({o.alu, o.rd, o.ldr} !== {32'h55, 4'd4, 32'h0}) $display("FAIL alu_w got %h want %h", o, e); else passed++;
  endtask

  task automatic test_reset_busy;
    out_t o, e; int st, es; bit bb; in_t x;
    x = mk(0, 1, 0, 32'h40, 32'h11111111, 4'd0);
    model(1, x, e, es); issue(1, x, st, bb, o);
    a3 = mk(0, 1, 0, 32'h40, 32'hA5A5A5A5, 4'd0);
    @(posedge clk); #1;
    total++; if (s3 !== 1'b1) $display("FAIL rb_busy got %b want 1", s3); else passed++;
    @(negedge clk); rst = 1; #1;
    total++; if (s3 !== 1'b0) $display("FAIL rb_stall got %b want 0", s3); else passed++;
    a3 = '0;
    @(negedge clk); rst = 0;
    x = mk(1, 0, 1, 32'h40, 32'h0, 4'd2);
    model(1, x, e, es); issue(1, x, st, bb, o);
    total++; if (o.ldr !== 32'h11111111) $display("FAIL rb_ld got %h want 11111111", o.ldr); else passed++;
  endtask

  task automatic test_alias;
    out_t o, e; int st, es; bit bb; in_t x;
    x = mk(0, 1, 0, 32'h1000, 32'h77, 4'd0);
    model(1, x, e, es); issue(1, x, st, bb, o);
    x = mk(1, 0, 1, 32'h0, 32'h0, 4'd3);
    model(1, x, e, es); issue(1, x, st, bb, o);
    total++; if (o.ldr !== 32'h77) $display("FAIL alias_ld got %h want 77", o.ldr); else passed++;
  endtask

  task automatic test_illegal;
    out_t o, e; int st, es; bit bb; in_t x;
    x = mk(0, 1, 0, 32'h80, 32'hCAFE0001, 4'd0);
    model(1, x, e, es); issue(1, x, st, bb, o);
    x = mk(1, 1, 1, 32'h80, 32'hCAFE0002, 4'd5);
    model(1, x, e, es); issue(1, x, st, bb, o);
    total++; if (o.ldr !== 32'hCAFE0001) $display("FAIL illegal_pre got %h want cafe0001", o.ldr); else passed++;
    x = mk(1, 0, 1, 32'h80, 32'h0, 4'd5);
    model(1, x, e, es); issue(1, x, st, bb, o);
    total++; if (o.ldr !== 32'hCAFE0002) $display("FAIL illegal_post got %h want cafe0002", o.ldr); else passed++;
  endtask

  task automatic test_back_to_back;
    out_t o, e; int st, es; bit bb; in_t x; bit s;
    for (int n = 0; n < 60; n++) begin
      int r;
      s = n[0];
      r = $urandom_range(0, 7);
      x = mk(r inside {1, 2, 3}, r inside {4, 5, 6}, 1'($urandom), 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3)), $urandom, 4'($urandom));
      x.call = 1'($urandom);
      model(s, x, e, es); issue(s, x, st, bb, o);
      total++; if (st !== es) $display("FAIL rand%0d_stall lat%0d got %0d want %0d", n, s ? 3 : 1, st, es); else passed++;
      total++; if (bb !== 1'b0) $display("FAIL rand%0d_bubble got %b want 0", n, bb); else passed++;
      total++; if (o !== e) $display("FAIL rand%0d_w got %h want %h", n, o, e); else passed++;
    end
  endtask

  task automatic test_reset_traffic;
    a1 = mk(0, 0, 1, 32'h1234, 32'h0, 4'd6);
    a3 = mk(1, 0, 1, 32'h20, 32'h0, 4'd8);
    @(posedge clk); #1;
    total++; if (o1.alu !== 32'h1234) $display("FAIL rt_pre got %h want 1234", o1.alu); else passed++;
    total++; if (s3 !== 1'b1) $display("FAIL rt_busy got %b want 1", s3); else passed++;
    rst = 1; #1;
    total++; if ({o1, o3} !== '0) $display("FAIL rt_w got %h want 0", {o1, o3}); else passed++;
    total++; if ({s1, s3} !== 2'b00) $display("FAIL rt_stall got %b want 00", {s1, s3}); else passed++;
    @(negedge clk); a1 = '0; a3 = '0; rst = 0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin m1[i] = '0; m3[i] = '0; end
    test_reset;
    test_lat1;
    test_lat3_load;
    test_alu;
    test_reset_busy;
    test_alias;
    test_illegal;
    test_back_to_back;
    test_reset_traffic;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
